// File: rtl/pj_pin_tape_checker.sv
// pj_pin_tape_checker: compares sampled picoJava-II pin vectors against a masked expected tape,
// counting mismatches and capturing the first failure.
module pj_pin_tape_checker #(
  parameter int VEC_W = 110,
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int STOP_ON_FAIL = 0
)(
  input  logic             clk,
  input  logic             reset_l,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [VEC_W-1:0] ld_exp,
  input  logic [VEC_W-1:0] ld_mask,
  input  logic [AW:0]      tape_len,
  input  logic             start,
  input  logic             abort,
  input  logic             smp_en,
  input  logic [VEC_W-1:0] live_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err,
  output logic [15:0]      mis_cnt,
  output logic [AW:0]      idx,
  output logic             ff_valid,
  output logic [AW-1:0]    ff_idx,
  output logic [VEC_W-1:0] ff_diff
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [VEC_W-1:0] mem_exp [DEPTH];
  logic [VEC_W-1:0] mem_mask [DEPTH];
  logic [AW:0] len;
  logic aborted, cmp, mis;
  logic [VEC_W-1:0] diff;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && mis_cnt == 16'd0 && !aborted;
  assign cmp = busy && smp_en && !abort && idx < len;
  assign diff = (live_vec ^ mem_exp[idx[AW-1:0]]) & mem_mask[idx[AW-1:0]];
  assign mis = |diff;
  // tape memory is deliberately outside the reset domain
  always_ff @(posedge clk)
    if (ld_en && !busy) begin
      mem_exp[ld_addr] <= ld_exp;
      mem_mask[ld_addr] <= ld_mask;
    end
  always_ff @(posedge clk)
    if (!reset_l) begin
      state <= IDLE;
      len <= '0;
      idx <= '0;
      mis_cnt <= '0;
      err <= 1'b0;
      aborted <= 1'b0;
      ff_valid <= 1'b0;
      ff_idx <= '0;
      ff_diff <= '0;
    end else begin
      err <= cmp && mis;
      if (!busy) begin
        if (start) begin
          state <= RUN;
          len <= tape_len;
          idx <= '0;
          mis_cnt <= '0;
          aborted <= 1'b0;
          ff_valid <= 1'b0;
          ff_idx <= '0;
          ff_diff <= '0;
        end
      end else if (abort) begin
        state <= DONE;
        aborted <= 1'b1;
      end else if (cmp) begin
        idx <= idx + 1'b1;
        if (mis) begin
          mis_cnt <= mis_cnt + {15'd0, ~&mis_cnt};
          if (!ff_valid) begin
            ff_valid <= 1'b1;
            ff_idx <= idx[AW-1:0];
            ff_diff <= diff;
          end
        end
        if (idx + 1'b1 == len || (STOP_ON_FAIL != 0 && mis)) state <= DONE;
      end else if (idx >= len) state <= DONE;
    end
endmodule

// File: tb/tb_pj_pin_tape_checker.sv
// tb_pj_pin_tape_checker: directed checks of the pin tape checker, with a second
// instance built to stop on the first failure.
module tb_pj_pin_tape_checker;
  logic clk = 0, reset_l = 0, ld_en = 0, start = 0, abort = 0, smp_en = 0;
  logic [9:0] ld_addr = 0;
  logic [109:0] ld_exp = 0, ld_mask = 0, live_vec = 0;
  logic [10:0] tape_len = 0;
  logic busy0, done0, pass0, err0, ff_valid0, busy1, done1, pass1, err1, ff_valid1;
  logic [15:0] mis0, mis1;
  logic [10:0] idx0, idx1;
  logic [9:0] ffi0, ffi1;
  logic [109:0] ffd0, ffd1;
  int n_chk = 0, n_fail = 0;
  logic [109:0] full, flip;
  logic [7:0] errs;
  int cyc;

  always #5 clk = ~clk;

  pj_pin_tape_checker #(.STOP_ON_FAIL(0)) u0 (.clk(clk), .reset_l(reset_l), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_exp(ld_exp), .ld_mask(ld_mask), .tape_len(tape_len), .start(start),
    .abort(abort), .smp_en(smp_en), .live_vec(live_vec), .busy(busy0), .done(done0), .pass(pass0),
    .err(err0), .mis_cnt(mis0), .idx(idx0), .ff_valid(ff_valid0), .ff_idx(ffi0), .ff_diff(ffd0));
  pj_pin_tape_checker #(.STOP_ON_FAIL(1)) u1 (.clk(clk), .reset_l(reset_l), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_exp(ld_exp), .ld_mask(ld_mask), .tape_len(tape_len), .start(start),
    .abort(abort), .smp_en(smp_en), .live_vec(live_vec), .busy(busy1), .done(done1), .pass(pass1),
    .err(err1), .mis_cnt(mis1), .idx(idx1), .ff_valid(ff_valid1), .ff_idx(ffi1), .ff_diff(ffd1));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // dataout sits at bits 103:72; entry 2 carries 32'h0000_00FF
  function automatic logic [109:0] vec(input int i);
    logic [31:0] d;
    d = (i == 2) ? 32'h0000_00FF : 32'h0000_1000 + i;
    return {6'(i + 1), d, 72'(i * 37 + 11)};
  endfunction

  task automatic load(input int n, input logic [109:0] m);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_en = 1; ld_addr = 10'(i); ld_exp = vec(i); ld_mask = m;
    end
    @(negedge clk);
    ld_en = 0;
  endtask

  // errs[k] holds err seen one cycle after sample k; cycles counts negedges until both done
  task automatic run(input int n, input logic [7:0] bad, input bit gap, input int ab,
                     output logic [7:0] errs, output int cycles);
    int i, p;
    bit tog;
    i = 0; p = -1; tog = 0; errs = 0; cycles = 0;
    @(negedge clk);
    tape_len = 11'(n); start = 1;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      start = 0; abort = 0; smp_en = 0;
      if (p >= 0) errs[p] = err0;
      p = -1;
      cycles = c;
      if (done0 && done1) break;
      if (c == 99) check("run_timeout", 0, 1);
      if (i < n) begin
        if (gap && tog) tog = 0;
        else begin
          tog = 1;
          smp_en = 1;
          live_vec = vec(i) ^ (bad[i] ? flip : 110'd0);
          if (i == ab) begin abort = 1; i = n; end
          else begin p = i; i++; end
        end
      end
    end
    smp_en = 0; abort = 0;
  endtask

  initial begin
    full = '1;
    flip = 110'd1 << 72;
    repeat (2) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_mis", mis0, 0);
    check("rst_idx", idx0, 0);
    check("rst_ffv", ff_valid0, 0);
    reset_l = 1;

    load(4, full);
    run(4, 8'h00, 0, -1, errs, cyc);
    check("clean_done", done0, 1);
    check("clean_pass", pass0, 1);
    check("clean_mis", mis0, 0);
    check("clean_errs", errs, 0);
    check("clean_idx", idx0, 4);

    run(4, 8'h04, 0, -1, errs, cyc);
    check("mis_errs", errs, 8'h04);
    check("mis_cnt", mis0, 1);
    check("mis_ffv", ff_valid0, 1);
    check("mis_ffidx", ffi0, 2);
    check("mis_ffdiff", ffd0, flip);
    check("mis_pass", pass0, 0);

    load(4, full & ~flip);
    check("ld_done_done", done0, 1);
    check("ld_done_pass", pass0, 0);
    run(4, 8'h04, 0, -1, errs, cyc);
    check("masked_pass", pass0, 1);
    check("masked_mis", mis0, 0);

    load(4, full);
    run(4, 8'h04, 1, -1, errs, cyc);
    check("gap_errs", errs, 8'h04);
    check("gap_mis", mis0, 1);
    check("gap_ffidx", ffi0, 2);
    check("gap_idx", idx0, 4);

    run(4, 8'h0A, 0, -1, errs, cyc);
    check("stop_done", done1, 1);
    check("stop_mis", mis1, 1);
    check("stop_idx", idx1, 2);
    check("stop_ffidx", ffi1, 1);
    check("nostop_mis", mis0, 2);
    check("nostop_idx", idx0, 4);

    run(0, 8'h00, 0, -1, errs, cyc);
    check("len0_cycles", cyc, 2);
    check("len0_pass", pass0, 1);
    check("len0_idx", idx0, 0);

    load(8, full);
    run(8, 8'h00, 0, 2, errs, cyc);
    check("abort_done", done0, 1);
    check("abort_pass", pass0, 0);
    check("abort_idx", idx0, 2);
    check("abort_mis", mis0, 0);

    @(negedge clk);
    tape_len = 8; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      smp_en = 1; live_vec = vec(i) ^ (i == 0 ? flip : 110'd0);
      @(negedge clk);
    end
    smp_en = 0;
    check("pre_rst_mis", mis0, 1);
    check("pre_rst_busy", busy0, 1);
    reset_l = 0;
    @(negedge clk);
    reset_l = 1;
    check("midrst_busy", busy0, 0);
    check("midrst_mis", mis0, 0);
    check("midrst_idx", idx0, 0);
    check("midrst_ffv", ff_valid0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
